lpddr3_dqs_delay_trainer: RTL and testbench

Per-lane training controller on the fabric side of the LPDDR3 DQS IOD lane. It drives the lane's delay-line control (move, direction, load) and eye-monitor clear. It consumes the eye-monitor early/late flags and the out-of-range flag. It sweeps the DQS delay tap upward, finds the left and right edges of the clean eye window, then parks the tap at the window centre.

---
 rtl/dqs_train_pkg.sv | 37 +++
 rtl/lpddr3_dqs_delay_trainer_if.sv | 25 ++
 rtl/dqs_eye_window_sampler.sv | 69 ++++++
 rtl/lpddr3_dqs_delay_trainer.sv | 181 ++++++++++++++++++
 tb/tb_lpddr3_dqs_delay_trainer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dqs_train_pkg.sv
// Shared types and constants for the LPDDR3 DQS delay trainer.
package dqs_train_pkg;

  localparam int TAP_W = 8;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_MOVE,
    ST_GAP,
    ST_CENTER,
    ST_DONE,
    ST_ERR
  } train_state_e;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_SETTLE,
    SP_SAMPLE
  } sampler_phase_e;

  // Sum is formed one bit wider so LEFT + RIGHT near the top tap cannot wrap.
  function automatic logic [TAP_W-1:0] window_centre(input logic [TAP_W-1:0] left,
                                                     input logic [TAP_W-1:0] right);
    logic [TAP_W:0] sum;
    sum = {1'b0, left} + {1'b0, right};
    return sum[TAP_W:1];
  endfunction

endpackage

// File: rtl/lpddr3_dqs_delay_trainer_if.sv
// Fabric-side control/status bundle of one LPDDR3 DQS IOD lane.
interface lpddr3_dqs_delay_trainer_if;

  logic       DELAY_LINE_MOVE_0;
  logic       DELAY_LINE_DIRECTION_0;
  logic       DELAY_LINE_LOAD_0;
  logic       EYE_MONITOR_CLEAR_FLAGS_0;
  logic [2:0] EYE_MONITOR_LANE_WIDTH;
  logic       EYE_MONITOR_EARLY_0;
  logic       EYE_MONITOR_LATE_0;
  logic       DELAY_LINE_OUT_OF_RANGE_0;

  modport master (
    output DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0,
           EYE_MONITOR_CLEAR_FLAGS_0, EYE_MONITOR_LANE_WIDTH,
    input  EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0
  );

  modport slave (
    input  DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0,
           EYE_MONITOR_CLEAR_FLAGS_0, EYE_MONITOR_LANE_WIDTH,
    output EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0
  );

endinterface

// File: rtl/dqs_eye_window_sampler.sv
// Settle-then-observe window: waits SETTLE_CYCLES, then ORs early|late for SAMPLE_CYCLES.
module dqs_eye_window_sampler
  import dqs_train_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic cancel,
  input  logic early,
  input  logic late,
  output logic sampling,
  output logic done,
  output logic bad
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);

  sampler_phase_e phase, next_phase;
  logic [7:0]     cnt;
  logic           last;

  always_comb begin
    next_phase = phase;
    last       = 1'b0;
    case (phase)
      SP_IDLE:   if (start) next_phase = SP_SETTLE;
      SP_SETTLE: if (cnt == SETTLE_LAST) next_phase = SP_SAMPLE;
      SP_SAMPLE: if (cnt == SAMPLE_LAST) begin
        next_phase = SP_IDLE;
        last       = 1'b1;
      end
      default:   next_phase = SP_IDLE;
    endcase
    if (cancel) begin
      next_phase = SP_IDLE;
      last       = 1'b0;
    end else if (start) begin
      next_phase = SP_SETTLE;
      last       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= SP_IDLE;
    else        phase <= next_phase;
  end

  // bad is held after done so the controller can evaluate it a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      bad  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (cancel || phase != next_phase) cnt <= '0;
      else if (phase != SP_IDLE)         cnt <= cnt + 8'd1;
      if (!cancel && start)                         bad <= 1'b0;
      else if (!cancel && phase == SP_SAMPLE)       bad <= bad | early | late;
    end
  end

  assign sampling = (phase == SP_SAMPLE);

endmodule

// File: rtl/lpddr3_dqs_delay_trainer.sv
// Per-lane DQS delay trainer: sweeps the tap up, finds the clean eye edges, parks at the centre.
// Optional macro DQS_TRAIN_DEBUG_EN adds LEFT_TAP, RIGHT_TAP and SWEEP_ERR_CNT outputs.
module lpddr3_dqs_delay_trainer
  import dqs_train_pkg::*;
#(
  parameter int         TAP_MAX       = 127,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         SAMPLE_CYCLES = 16,
  parameter logic [2:0] LANE_WIDTH    = 3'b001
) (
  input  logic                        FAB_CLK,
  input  logic                        ARST_N,
  input  logic                        START,
  input  logic                        ABORT,
  lpddr3_dqs_delay_trainer_if.master  lane,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERROR,
  output logic [TAP_W-1:0]            TAP
`ifdef DQS_TRAIN_DEBUG_EN
  ,
  output logic [TAP_W-1:0]            LEFT_TAP,
  output logic [TAP_W-1:0]            RIGHT_TAP,
  output logic [7:0]                  SWEEP_ERR_CNT
`endif
);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_MAX);

  train_state_e     state, next_state;
  logic [TAP_W-1:0] tap, left, right, target;
  logic             left_found, in_center, aborting, dir;
  logic             busy_q, done_q, error_q;
  logic             sampler_start, sampling, sample_done, bad, oor;

  assign oor    = lane.DELAY_LINE_OUT_OF_RANGE_0;
  assign target = window_centre(left, right);

  dqs_eye_window_sampler #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_sampler (
    .clk     (FAB_CLK),
    .rst_n   (ARST_N),
    .start   (sampler_start),
    .cancel  (ABORT),
    .early   (lane.EYE_MONITOR_EARLY_0),
    .late    (lane.EYE_MONITOR_LATE_0),
    .sampling(sampling),
    .done    (sample_done),
    .bad     (bad)
  );

  always_comb begin
    next_state    = state;
    sampler_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (START) next_state = ST_LOAD;
      ST_LOAD:   next_state = aborting ? ST_IDLE : ST_CLEAR;
      ST_CLEAR: begin
        sampler_start = 1'b1;
        next_state    = ST_SETTLE;
      end
      ST_SETTLE: if (sampling) next_state = ST_SAMPLE;
      ST_SAMPLE: if (sample_done) next_state = ST_EVAL;
      ST_EVAL: begin
        if (left_found && bad)   next_state = ST_CENTER;
        else if (tap == TAP_LAST) next_state = (left_found || !bad) ? ST_CENTER : ST_ERR;
        else                      next_state = ST_MOVE;
      end
      ST_MOVE:   next_state = ST_GAP;
      ST_GAP: begin
        if (in_center) next_state = ST_CENTER;
        else if (oor)  next_state = left_found ? ST_CENTER : ST_ERR;
        else           next_state = ST_CLEAR;
      end
      // The tap can never sit below the centre; treat that as a broken sweep.
      ST_CENTER: begin
        if (tap > target)       next_state = ST_MOVE;
        else if (tap == target) next_state = ST_DONE;
        else                    next_state = ST_ERR;
      end
      default:   next_state = ST_IDLE;
    endcase
    if (ABORT) begin
      next_state    = ST_LOAD;
      sampler_start = 1'b0;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) state <= ST_IDLE;
    else         state <= next_state;
  end

  // The tap mirrors the delay line, so it follows every pulse even while aborting.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N)                tap <= '0;
    else if (state == ST_LOAD)  tap <= '0;
    else if (state == ST_MOVE)  tap <= (dir == DIR_INC) ? tap + 8'd1 : tap - 8'd1;
  end

  // Direction flips on entry to CENTER, a full cycle ahead of the first decrement.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      left       <= '0;
      right      <= '0;
      left_found <= 1'b0;
      in_center  <= 1'b0;
      aborting   <= 1'b0;
      dir        <= DIR_INC;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else if (ABORT) begin
      aborting <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: if (START) begin
          done_q     <= 1'b0;
          error_q    <= 1'b0;
          busy_q     <= 1'b1;
          left_found <= 1'b0;
          in_center  <= 1'b0;
          aborting   <= 1'b0;
          dir        <= DIR_INC;
        end
        ST_EVAL: begin
          if (!left_found && !bad) begin
            left       <= tap;
            left_found <= 1'b1;
          end
          if (left_found && bad)                          right <= tap - 8'd1;
          else if (tap == TAP_LAST && (left_found || !bad)) right <= TAP_LAST;
        end
        ST_GAP: if (!in_center && oor && left_found) right <= tap - 8'd1;
        default: ;
      endcase
      if (next_state == ST_CENTER) begin
        in_center <= 1'b1;
        dir       <= DIR_DEC;
      end
      if (next_state == ST_DONE && state != ST_DONE) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
      if (next_state == ST_ERR && state != ST_ERR) begin
        error_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

`ifdef DQS_TRAIN_DEBUG_EN
  logic [7:0] err_cnt;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N)                                           err_cnt <= '0;
    else if (!ABORT && START && (state == ST_IDLE || state == ST_DONE || state == ST_ERR))
                                                           err_cnt <= '0;
    else if (state == ST_EVAL && bad && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
  end

  assign LEFT_TAP      = left;
  assign RIGHT_TAP     = right;
  assign SWEEP_ERR_CNT = err_cnt;
`endif

  assign lane.DELAY_LINE_MOVE_0         = (state == ST_MOVE);
  assign lane.DELAY_LINE_LOAD_0         = (state == ST_LOAD);
  assign lane.EYE_MONITOR_CLEAR_FLAGS_0 = (state == ST_CLEAR);
  assign lane.DELAY_LINE_DIRECTION_0    = dir;
  assign lane.EYE_MONITOR_LANE_WIDTH    = LANE_WIDTH;

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERROR = error_q;
  assign TAP   = tap;

endmodule

// File: tb/tb_lpddr3_dqs_delay_trainer.sv
// Bench for lpddr3_dqs_delay_trainer: IOD lane model plus a sweep-level reference model.
module tb_lpddr3_dqs_delay_trainer;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic       START   = 1'b0;
  logic       ABORT   = 1'b0;
  logic       BUSY, DONE, ERROR;
  logic [7:0] TAP;
`ifdef DQS_TRAIN_DEBUG_EN
  logic [7:0] LEFT_TAP, RIGHT_TAP, SWEEP_ERR_CNT;
`endif

  lpddr3_dqs_delay_trainer_if lane();

  lpddr3_dqs_delay_trainer dut (
    .FAB_CLK      (FAB_CLK),
    .ARST_N       (ARST_N),
    .START        (START),
    .ABORT        (ABORT),
    .lane         (lane),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERROR        (ERROR),
    .TAP          (TAP)
`ifdef DQS_TRAIN_DEBUG_EN
    ,
    .LEFT_TAP     (LEFT_TAP),
    .RIGHT_TAP    (RIGHT_TAP),
    .SWEEP_ERR_CNT(SWEEP_ERR_CNT)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Lane model: a delay line that follows LOAD/MOVE and sticky eye flags cleared by CLEAR.
  logic [127:0] clean_mask  = '0;
  int           oor_at      = 1000;
  logic [7:0]   iod_tap     = '0;
  int           inc_total   = 0;
  int           dec_total   = 0;
  int           load_total  = 0;
  int           clear_total = 0;
  int           cyc         = 0;
  int           last_move   = -10;
  logic         prev_dir    = 1'b1;

  assign lane.DELAY_LINE_OUT_OF_RANGE_0 = (int'(iod_tap) >= oor_at);

  always @(negedge FAB_CLK) begin
    cyc      <= cyc + 1;
    prev_dir <= lane.DELAY_LINE_DIRECTION_0;
    if (lane.DELAY_LINE_LOAD_0) begin
      iod_tap    <= '0;
      load_total <= load_total + 1;
    end else if (lane.DELAY_LINE_MOVE_0) begin
      check_output("move_spacing", (cyc - last_move >= 2) ? 1 : 0, 1);
      check_output("dir_stable", int'(lane.DELAY_LINE_DIRECTION_0), int'(prev_dir));
      last_move <= cyc;
      if (lane.DELAY_LINE_DIRECTION_0) begin
        iod_tap   <= iod_tap + 8'd1;
        inc_total <= inc_total + 1;
      end else begin
        iod_tap   <= iod_tap - 8'd1;
        dec_total <= dec_total + 1;
      end
    end
    if (lane.EYE_MONITOR_CLEAR_FLAGS_0) clear_total <= clear_total + 1;
    if (!ARST_N || lane.EYE_MONITOR_CLEAR_FLAGS_0) begin
      lane.EYE_MONITOR_EARLY_0 <= 1'b0;
      lane.EYE_MONITOR_LATE_0  <= 1'b0;
    end else if (!clean_mask[iod_tap[6:0]]) begin
      if ($urandom_range(0, 1) == 1) lane.EYE_MONITOR_EARLY_0 <= 1'b1;
      else                           lane.EYE_MONITOR_LATE_0  <= 1'b1;
    end
  end

  function automatic logic [127:0] make_mask(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Walks the taps the way the sweep is described: find first clean tap, stop at first bad one.
  task automatic model_run(input logic [127:0] mask, input int oor_tap,
                           output bit m_err, output int m_left, output int m_right,
                           output int m_final, output int m_incs, output int m_decs,
                           output int m_bad);
    bit found;
    int t;
    found = 0; t = 0;
    m_err = 0; m_left = 0; m_right = 0; m_incs = 0; m_bad = 0;
    while (1) begin
      if (!mask[t]) m_bad++;
      if (!found && mask[t]) begin
        m_left = t;
        found  = 1;
      end else if (found && !mask[t]) begin
        m_right = t - 1;
        break;
      end
      if (t == 127) begin
        if (found) m_right = 127;
        else       m_err = 1;
        break;
      end
      t++;
      m_incs++;
      if (t >= oor_tap) begin
        if (found) m_right = t - 1;
        else       m_err = 1;
        break;
      end
    end
    m_final = m_err ? t : (m_left + m_right) / 2;
    m_decs  = t - m_final;
    if (m_bad > 255) m_bad = 255;
  endtask

  task automatic apply_stimulus(input string name, input logic [127:0] mask,
                                input int oor_tap, input bit poke_start);
    bit m_err;
    int m_left, m_right, m_final, m_incs, m_decs, m_bad;
    int l0, i0, d0, n;
    model_run(mask, oor_tap, m_err, m_left, m_right, m_final, m_incs, m_decs, m_bad);
    clean_mask = mask;
    oor_at     = oor_tap;
    l0 = load_total; i0 = inc_total; d0 = dec_total;
    @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    n = 0;
    while (!(DONE || ERROR) && n < 10000) begin
      @(negedge FAB_CLK);
      START = poke_start && ($urandom_range(0, 99) == 0);
      n++;
    end
    START = 1'b0;
    #1;
    check_output({name, ":finished"}, (n < 10000) ? 1 : 0, 1);
    check_output({name, ":done"},  int'(DONE),  m_err ? 0 : 1);
    check_output({name, ":error"}, int'(ERROR), m_err ? 1 : 0);
    check_output({name, ":busy"},  int'(BUSY),  0);
    check_output({name, ":tap"},   int'(TAP),   m_final);
    check_output({name, ":lane_tap"}, int'(iod_tap), m_final);
    check_output({name, ":incs"},  inc_total - i0, m_incs);
    check_output({name, ":decs"},  dec_total - d0, m_err ? 0 : m_decs);
    check_output({name, ":loads"}, load_total - l0, 1);
`ifdef DQS_TRAIN_DEBUG_EN
    if (!m_err) begin
      check_output({name, ":left"},  int'(LEFT_TAP),  m_left);
      check_output({name, ":right"}, int'(RIGHT_TAP), m_right);
    end
    check_output({name, ":sweep_err_cnt"}, int'(SWEEP_ERR_CNT), m_bad);
`endif
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, ":tap"},   int'(TAP),   0);
    check_output({name, ":busy"},  int'(BUSY),  0);
    check_output({name, ":done"},  int'(DONE),  0);
    check_output({name, ":error"}, int'(ERROR), 0);
    check_output({name, ":move"},  int'(lane.DELAY_LINE_MOVE_0), 0);
    check_output({name, ":load"},  int'(lane.DELAY_LINE_LOAD_0), 0);
    check_output({name, ":clear"}, int'(lane.EYE_MONITOR_CLEAR_FLAGS_0), 0);
    check_output({name, ":dir"},   int'(lane.DELAY_LINE_DIRECTION_0), 1);
    check_output({name, ":lane_width"}, int'(lane.EYE_MONITOR_LANE_WIDTH), 1);
`ifdef DQS_TRAIN_DEBUG_EN
    check_output({name, ":left"},  int'(LEFT_TAP),  0);
    check_output({name, ":right"}, int'(RIGHT_TAP), 0);
`endif
  endtask

  initial begin
    int l0, m0, c0, d0, n, lo, hi, kind;
    repeat (3) @(negedge FAB_CLK);
    #1;
    check_reset_values("reset");
    @(negedge FAB_CLK);
    ARST_N = 1'b1;

    apply_stimulus("eye20_40", make_mask(20, 40), 1000, 1'b0);
    apply_stimulus("always_bad", '0, 1000, 1'b0);
    apply_stimulus("oor110", make_mask(100, 127), 110, 1'b0);
    apply_stimulus("start_poke", make_mask(20, 40), 1000, 1'b1);

    for (int r = 0; r < 5; r++) begin
      lo   = $urandom_range(0, 110);
      hi   = $urandom_range(lo, 127);
      kind = $urandom_range(0, 3);
      if (kind == 0)      apply_stimulus("rand_oor", make_mask(lo, hi), $urandom_range(lo + 1, 127), 1'b0);
      else if (kind == 1) apply_stimulus("rand_poke", make_mask(lo, hi), 1000, 1'b1);
      else                apply_stimulus("rand_eye", make_mask(lo, hi), 1000, 1'b0);
    end

    // Abort at tap 15 while the sampler is observing.
    clean_mask = make_mask(10, 50);
    oor_at     = 1000;
    @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    n = 0;
    while (iod_tap != 8'd15 && n < 2000) begin
      @(negedge FAB_CLK);
      n++;
    end
    check_output("abort:reached_tap15", (n < 2000) ? 1 : 0, 1);
    repeat (15) @(negedge FAB_CLK);
    l0 = load_total;
    ABORT = 1'b1;
    @(negedge FAB_CLK);
    ABORT = 1'b0;
    @(negedge FAB_CLK);
    #1;
    check_output("abort:loads", load_total - l0, 1);
    check_output("abort:tap",   int'(TAP),   0);
    check_output("abort:busy",  int'(BUSY),  0);
    check_output("abort:done",  int'(DONE),  0);
    check_output("abort:error", int'(ERROR), 0);
    m0 = inc_total + dec_total;
    repeat (40) @(negedge FAB_CLK);
    #1;
    check_output("abort:idle_loads", load_total - l0, 1);
    check_output("abort:idle_moves", inc_total + dec_total - m0, 0);
    check_output("abort:idle_busy",  int'(BUSY), 0);

    // Simultaneous ABORT and START from idle: ABORT wins, no sweep starts.
    l0 = load_total;
    c0 = clear_total;
    @(negedge FAB_CLK);
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    ABORT = 1'b0;
    repeat (20) @(negedge FAB_CLK);
    #1;
    check_output("abort_start:loads",  load_total - l0, 1);
    check_output("abort_start:clears", clear_total - c0, 0);
    check_output("abort_start:busy",   int'(BUSY), 0);

    // Asynchronous reset while centring.
    clean_mask = make_mask(20, 40);
    d0 = dec_total;
    @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    n = 0;
    while (dec_total - d0 < 3 && n < 5000) begin
      @(negedge FAB_CLK);
      n++;
    end
    check_output("rst_mid:reached_center", (n < 5000) ? 1 : 0, 1);
    #2;
    ARST_N = 1'b0;
    #1;
    check_reset_values("rst_mid");
    repeat (2) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    apply_stimulus("after_reset", make_mask(20, 40), 1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
